// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_pkg
// Brief   : Shared constants, FSM states and IF/ID layout for the fetch stage.
// Revision: 1.0
// ============================================================================
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          IFID_W    = 65;

  typedef enum logic [1:0] {
    FS_REQ     = 2'd0,
    FS_WAIT    = 2'd1,
    FS_HOLD    = 2'd2,
    FS_DISCARD = 2'd3
  } fetchState_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

  // A bubble keeps the PC field so downstream still sees the last D-stage PC.
  localparam logic [IFID_W-1:0] IFID_KEEP_MASK = {32'h0, 32'hFFFF_FFFF, 1'b0};

endpackage
`default_nettype wire

// File: rtl/fetch_stage_flopenrc.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_flopenrc
// Brief   : Enabled register with async reset and masked synchronous clear.
// Revision: 1.0
// ============================================================================
module fetch_stage_flopenrc #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] KEEP_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear zeroes every bit not selected by KEEP_MASK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? (q & KEEP_MASK) : d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : Fetch PC, single-outstanding imem port FSM and IF/ID register.
// Revision: 1.0
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD
);

  fetchState_t r_state;
  fetchState_t w_stateNext;
  logic [31:0] r_pcF;
  logic [31:0] r_bufInstr;
  logic [31:0] r_pendPc;
  logic        r_pendValid;
  logic        w_accept;
  logic [31:0] w_acceptInstr;
  logic [31:0] w_nextPc;
  ifid_t       w_ifidD;
  ifid_t       w_ifidQ;

  always_comb begin
    w_stateNext   = r_state;
    w_accept      = 1'b0;
    w_acceptInstr = r_bufInstr;
    case (r_state)
      FS_REQ: begin
        // A request accepted in the flush cycle still owes a response.
        if (exc_valid)         w_stateNext = inst_addr_ok ? FS_DISCARD : FS_REQ;
        else if (inst_addr_ok) w_stateNext = FS_WAIT;
      end
      FS_WAIT: begin
        if (exc_valid) begin
          w_stateNext = inst_data_ok ? FS_REQ : FS_DISCARD;
        end else if (inst_data_ok) begin
          if (!stallD) begin
            w_accept      = 1'b1;
            w_acceptInstr = inst_rdata;
            w_stateNext   = FS_REQ;
          end else begin
            w_stateNext = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (exc_valid) begin
          w_stateNext = FS_REQ;
        end else if (!stallD) begin
          w_accept    = 1'b1;
          w_stateNext = FS_REQ;
        end
      end
      FS_DISCARD: begin
        if (inst_data_ok) w_stateNext = FS_REQ;
      end
      default: w_stateNext = FS_REQ;
    endcase
  end

  assign w_nextPc = redirect_valid ? redirect_pc :
                    r_pendValid    ? r_pendPc    : r_pcF + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FS_REQ;
      r_pcF       <= RESET_PC;
      r_bufInstr  <= NOP_INSTR;
      r_pendValid <= 1'b0;
      r_pendPc    <= 32'h0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == FS_WAIT && inst_data_ok && stallD && !exc_valid)
        r_bufInstr <= inst_rdata;
      if (exc_valid)     r_pcF <= exc_pc;
      else if (w_accept) r_pcF <= w_nextPc;
      // The delay slot is still in flight: remember the target until it lands.
      if (exc_valid || w_accept) begin
        r_pendValid <= 1'b0;
      end else if (redirect_valid && !stallD) begin
        r_pendValid <= 1'b1;
        r_pendPc    <= redirect_pc;
      end
    end
  end

  assign w_ifidD = '{instr: w_acceptInstr, pc: r_pcF, valid: 1'b1};

  fetch_stage_flopenrc #(
    .WIDTH    (IFID_W),
    .KEEP_MASK(IFID_KEEP_MASK)
  ) u_ifid (
    .clk(clk),
    .rst(rst),
    .en (~stallD | exc_valid),
    .clr(exc_valid | ~w_accept),
    .d  (w_ifidD),
    .q  (w_ifidQ)
  );

  assign inst_req  = (r_state == FS_REQ);
  assign inst_addr = r_pcF;
  assign instrD    = w_ifidQ.instr;
  assign pcD       = w_ifidQ.pc;
  assign validD    = w_ifidQ.valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed and randomized bench for fetch_stage with a memory model.
// Revision: 1.0
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD, redirect_valid, exc_valid;
  logic [31:0] redirect_pc, exc_pc;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [31:0] instrD, pcD;
  logic        validD;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallD(stallD),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .instrD(instrD), .pcD(pcD), .validD(validD)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          memLat  = 1;
  int          grantPct = 100;
  bit          memBusy = 1'b0;
  int          memCnt  = 0;
  logic [31:0] memAddr = 32'h0;
  bit          lastGrant = 1'b0;
  logic [31:0] expNext;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2468_ACE1;
  endfunction

  // One clock of the single-outstanding memory: inputs applied at negedge.
  task automatic step();
    bit          grant, resp;
    logic [31:0] reqAddr;
    grant   = !rst && inst_req && !memBusy && ($urandom_range(0, 99) < grantPct);
    resp    = memBusy && (memCnt == 1);
    reqAddr = inst_addr;
    inst_addr_ok = grant;
    inst_data_ok = resp;
    inst_rdata   = resp ? memWord(memAddr) : $urandom;
    lastGrant    = grant;
    @(posedge clk);
    if (resp)         memBusy = 1'b0;
    else if (memBusy) memCnt  = memCnt - 1;
    if (grant) begin
      memBusy = 1'b1;
      memCnt  = memLat;
      memAddr = reqAddr;
    end
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
  endtask

  task automatic waitDelivery(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (validD) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stallD = 0; redirect_valid = 0; exc_valid = 0;
    redirect_pc = 0; exc_pc = 0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    memBusy = 0;
    repeat (2) step();
    vectors++; if (inst_req !== 1'b1)    begin errors++; $display("FAIL reset_req got=%b exp=1", inst_req); end
    vectors++; if (inst_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", inst_addr, RST_PC); end
    vectors++; if (validD !== 1'b0 || instrD !== 32'h0 || pcD !== 32'h0)
      begin errors++; $display("FAIL reset_ifid got=%b/%h/%h exp=0/0/0", validD, instrD, pcD); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    memLat = 1; grantPct = 100;
    for (int i = 0; i < 6; i++) begin
      a = RST_PC + 32'(4 * (i / 2));
      if (i % 2 == 0) begin
        vectors++;
        if (inst_req !== 1'b1 || inst_addr !== a)
          begin errors++; $display("FAIL seq_req[%0d] got=%b/%h exp=1/%h", i, inst_req, inst_addr, a); end
      end
      step();
      vectors++;
      if (i % 2 == 1) begin
        if (validD !== 1'b1 || pcD !== a || instrD !== memWord(a))
          begin errors++; $display("FAIL seq_deliver[%0d] got=%b/%h/%h exp=1/%h/%h", i, validD, pcD, instrD, a, memWord(a)); end
      end else begin
        if (validD !== 1'b0 || instrD !== 32'h0)
          begin errors++; $display("FAIL seq_bubble[%0d] got=%b/%h exp=0/0", i, validD, instrD); end
      end
    end
    expNext = RST_PC + 32'd12;
  endtask

  task automatic test_branch();
    bit ok;
    for (int k = 0; k < 2; k++) begin
      waitDelivery(20, ok);
      vectors++;
      if (!ok || pcD !== expNext) begin errors++; $display("FAIL branch_pre got=%b/%h exp=1/%h", ok, pcD, expNext); end
      expNext += 4;
    end
    redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0100;
    step();
    redirect_valid = 1'b0;
    waitDelivery(20, ok);
    vectors++;
    if (!ok || pcD !== 32'hBFC0_0014) begin errors++; $display("FAIL branch_slot got=%b/%h exp=1/bfc00014", ok, pcD); end
    waitDelivery(20, ok);
    vectors++;
    if (!ok || pcD !== 32'hBFC0_0100 || instrD !== memWord(32'hBFC0_0100))
      begin errors++; $display("FAIL branch_target got=%b/%h/%h exp=1/bfc00100/%h", ok, pcD, instrD, memWord(32'hBFC0_0100)); end
    expNext = 32'hBFC0_0104;
  endtask

  task automatic test_pending_redirect();
    bit ok;
    memLat = 4;
    waitDelivery(20, ok);
    vectors++;
    if (!ok || pcD !== expNext) begin errors++; $display("FAIL pend_branch got=%b/%h exp=1/%h", ok, pcD, expNext); end
    redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0200;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if (dut.r_pendValid !== 1'b1) begin errors++; $display("FAIL pend_set got=%b exp=1", dut.r_pendValid); end
    waitDelivery(20, ok);
    vectors++;
    if (!ok || pcD !== expNext + 32'd4) begin errors++; $display("FAIL pend_slot got=%b/%h exp=1/%h", ok, pcD, expNext + 32'd4); end
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0200)
      begin errors++; $display("FAIL pend_addr got=%b/%h exp=1/bfc00200", inst_req, inst_addr); end
    waitDelivery(20, ok);
    vectors++;
    if (!ok || pcD !== 32'hBFC0_0200) begin errors++; $display("FAIL pend_target got=%b/%h exp=1/bfc00200", ok, pcD); end
    expNext = 32'hBFC0_0204;
  endtask

  task automatic test_stall_hold();
    memLat = 1;
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== expNext)
      begin errors++; $display("FAIL stall_req got=%b/%h exp=1/%h", inst_req, inst_addr, expNext); end
    step();
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (validD !== 1'b0 || instrD !== 32'h0 || pcD !== expNext - 32'd4 || inst_req !== 1'b0)
        begin errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%h req=%b exp=0/0/%h req=0", i, validD, instrD, pcD, inst_req, expNext - 32'd4); end
    end
    vectors++;
    if (dut.r_state !== fetch_stage_pkg::FS_HOLD) begin errors++; $display("FAIL stall_state got=%0d exp=HOLD", dut.r_state); end
    stallD = 1'b0;
    step();
    vectors++;
    if (validD !== 1'b1 || pcD !== expNext || instrD !== memWord(expNext))
      begin errors++; $display("FAIL stall_release got=%b/%h/%h exp=1/%h/%h", validD, pcD, instrD, expNext, memWord(expNext)); end
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== expNext + 32'd4)
      begin errors++; $display("FAIL stall_nodup got=%b/%h exp=1/%h", inst_req, inst_addr, expNext + 32'd4); end
    expNext += 4;
  endtask

  task automatic test_exception_wait();
    bit ok;
    memLat = 4;
    step();
    exc_valid = 1'b1; exc_pc = 32'hBFC0_0380;
    step();
    exc_valid = 1'b0;
    for (int i = 0; i < 10 && !inst_req; i++) begin
      vectors++;
      if (validD !== 1'b0) begin errors++; $display("FAIL exc_drop[%0d] got=%b exp=0", i, validD); end
      step();
    end
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380)
      begin errors++; $display("FAIL exc_addr got=%b/%h exp=1/bfc00380", inst_req, inst_addr); end
    waitDelivery(20, ok);
    vectors++;
    if (!ok || pcD !== 32'hBFC0_0380 || instrD !== memWord(32'hBFC0_0380))
      begin errors++; $display("FAIL exc_deliver got=%b/%h/%h exp=1/bfc00380/%h", ok, pcD, instrD, memWord(32'hBFC0_0380)); end
    expNext = 32'hBFC0_0384;
  endtask

  task automatic test_async_reset();
    memLat = 1;
    step();
    stallD = 1'b1;
    step();
    #2 rst = 1'b1;
    memBusy = 1'b0;
    #1;
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== RST_PC)
      begin errors++; $display("FAIL areset_req got=%b/%h exp=1/%h", inst_req, inst_addr, RST_PC); end
    vectors++;
    if (validD !== 1'b0 || instrD !== 32'h0 || pcD !== 32'h0)
      begin errors++; $display("FAIL areset_ifid got=%b/%h/%h exp=0/0/0", validD, instrD, pcD); end
    @(negedge clk);
    rst = 1'b0; stallD = 1'b0;
    expNext = RST_PC;
  endtask

  task automatic test_random();
    bit          tgtValid = 1'b0;
    logic [31:0] tgt = 32'h0;
    bit          loaded, reqBefore, exc;
    logic [31:0] addrBefore, ep;
    int          delivered = 0;
    grantPct = 70;
    for (int c = 0; c < 4000; c++) begin
      memLat         = $urandom_range(1, 4);
      stallD         = ($urandom_range(0, 99) < 30);
      exc            = ($urandom_range(0, 99) < 2);
      ep             = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      exc_valid      = exc;
      exc_pc         = ep;
      redirect_valid = !stallD && validD && ($urandom_range(0, 99) < 25);
      redirect_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (redirect_valid && !exc) begin
        tgtValid = 1'b1;
        tgt      = redirect_pc;
      end
      loaded     = !stallD || exc;
      reqBefore  = inst_req;
      addrBefore = inst_addr;
      step();
      redirect_valid = 1'b0;
      exc_valid      = 1'b0;
      if (exc) begin
        expNext  = ep;
        tgtValid = 1'b0;
        vectors++;
        if (validD !== 1'b0) begin errors++; $display("FAIL rand_exc_bubble c=%0d got=%b exp=0", c, validD); end
      end else if (loaded) begin
        vectors++;
        if (validD) begin
          if (pcD !== expNext || instrD !== memWord(expNext))
            begin errors++; $display("FAIL rand_deliver c=%0d got=%h/%h exp=%h/%h", c, pcD, instrD, expNext, memWord(expNext)); end
          expNext  = tgtValid ? tgt : expNext + 32'd4;
          tgtValid = 1'b0;
          delivered++;
        end else if (instrD !== 32'h0) begin
          errors++; $display("FAIL rand_bubble c=%0d got=%h exp=0", c, instrD);
        end
      end
      if (reqBefore && !lastGrant && !exc && inst_req) begin
        vectors++;
        if (inst_addr !== addrBefore)
          begin errors++; $display("FAIL rand_addr_stable c=%0d got=%h exp=%h", c, inst_addr, addrBefore); end
      end
    end
    stallD = 1'b0;
    vectors++;
    if (delivered < 100) begin errors++; $display("FAIL rand_progress got=%0d exp>=100", delivered); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_pending_redirect();
    test_stall_hold();
    test_exception_wait();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. It owns the fetch PC and drives a single-outstanding request/response instruction-memory port. It delivers `instrD`/`pcD` to the main decoder and honours the architectural branch delay slot. Redirects come from decode (branch/jump/jr) and from the exception unit. When memory is slow, bubbles (instr = 0, a NOP) are inserted, so the rest of the pipeline never waits on fetch.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stallD`  in  1  decode stage holds; IF/ID must not change
- `redirect_valid`  in  1  branch/jump in D resolved taken; sampled only when `stallD`=0
- `redirect_pc`  in  32  target of that branch/jump
- `exc_valid`  in  1  exception/eret flush; highest priority, ignores `stallD`
- `exc_pc`  in  32  handler or EPC address
- `inst_req`  out  1  request valid
- `inst_addr`  out  32  request address (= `pcF`)
- `inst_addr_ok`  in  1  request accepted this cycle
- `inst_data_ok`  in  1  response valid this cycle
- `inst_rdata`  in  32  response instruction
- `instrD`  out  32  instruction to decoder; 0 when bubble
- `pcD`  out  32  PC of `instrD`
- `validD`  out  1  `instrD` is a real instruction

## Operation
- Registers:
  - `pcF`: reset `RESET_PC`.
  - `state`: reset REQ.
  - `buf_instr`.
  - `pend_valid`/`pend_pc`: pending redirect; reset 0.
  - IF/ID: `instrD`, `pcD`, `validD`; reset 0/0/0.
- FSM states:
  - **REQ**: `inst_req`=1. On `inst_addr_ok` → WAIT.
  - **WAIT**: `inst_req`=0. On `inst_data_ok`:
    - if `stallD`=0, accept (below) → REQ;
    - else store `buf_instr` → HOLD.
  - **HOLD**: `inst_req`=0. When `stallD`=0, accept `buf_instr` → REQ.
  - **DISCARD**: `inst_req`=0. Wait for `inst_data_ok`, drop the data, → REQ.
- Accept means: IF/ID ← {instr, `pcF`, valid=1}, and `pcF` ← next.
- Next-PC selection when an instruction is accepted:
  - if `redirect_valid` is high this cycle, next = `redirect_pc`;
  - else if `pend_valid`, next = `pend_pc`, and clear `pend_valid`;
  - else next = `pcF`+4.
- Delay slot: the instruction fetched while the branch sits in D is the delay slot. It is always delivered; the target is fetched after it.
- When `stallD`=0 and no instruction is accepted: IF/ID loads a bubble {0, `pcD`, 0}.
- When `redirect_valid`=1 and `stallD`=0 and the delay slot is not accepted this cycle: set `pend_valid`/`pend_pc`.
- When `stallD`=1: IF/ID holds its value.
- `exc_valid`:
  - IF/ID ← bubble, `pend_valid` ← 0, `pcF` ← `exc_pc`.
  - Next state depends on the current state:
    - REQ or HOLD → REQ;
    - WAIT without `inst_data_ok` this cycle → DISCARD;
    - WAIT with `inst_data_ok` this cycle → REQ (data dropped).
  - `exc_valid` in DISCARD stays in DISCARD and updates `pcF`.
- In REQ, `inst_addr` = `pcF`. Address and request must stay stable until `addr_ok`; exception is the only thing allowed to change `pcF` while in REQ.
- `pcF` arithmetic is modulo 2^32; wrap-around is not trapped. Misalignment is detected downstream from `pcD`.

## Timing
- `inst_data_ok` in cycle N with `stallD`=0 → `instrD` valid at N+1.
- Minimum issue interval is 2 cycles per instruction: `addr_ok` in cycle N, `data_ok` in N+1, next request in N+2.
- A redirect takes effect on the first request issued after the delay slot is accepted.
- `exc_valid` in cycle N → `inst_addr` = `exc_pc` with `inst_req`=1 at N+1, or once DISCARD completes.
- Asynchronous reset mid-transaction returns to REQ at `RESET_PC`. The memory side is reset by the same `rst`.

## Structure
- `defines.vh`:
  - `RESET_PC`;
  - fetch FSM state encodings (`FS_REQ`, `FS_WAIT`, `FS_HOLD`, `FS_DISCARD`);
  - `NOP_INSTR` = 32'h0.
- Sub-module: the IF/ID register is one `flopenrc` instance, width 65, instantiated with enable = ~`stallD` | `exc_valid`. Clear is driven by the exception/bubble select logic.
- FSM, pending-redirect logic and PC mux live in `fetch_stage`.

## Test plan
- **Reset, then sequential fetch:**
  - Stimulus: `rst` pulse; memory returns `addr_ok` same cycle and `data_ok` one cycle later.
  - Required: `inst_addr` sequence 0xBFC00000, 0xBFC00004, 0xBFC00008. `pcD` matches, `validD`=1 every other cycle, with bubbles between.
- **Taken branch and delay slot:**
  - Stimulus: branch at 0xBFC00010 in D with `redirect_valid`=1, `redirect_pc`=0xBFC00100.
  - Required: 0xBFC00014 is delivered next, then 0xBFC00100.
- **Redirect while delay-slot fetch is pending:**
  - Stimulus: `data_ok` delayed 4 cycles.
  - Required: `pend_valid` is set; after the delay slot arrives, the next `inst_addr` = `pend_pc`.
- **Stall during response:**
  - Stimulus: `stallD`=1 for 3 cycles across `data_ok`.
  - Required: FSM goes to HOLD and `instrD` is unchanged; the buffered instruction appears the cycle after `stallD` falls, with no duplicate request.
- **Exception during WAIT:**
  - Stimulus: `exc_valid` with `exc_pc`=0xBFC00380 in WAIT.
  - Required: the late `data_ok` is dropped (`validD` stays 0), then `inst_addr`=0xBFC00380.
- **Asynchronous reset mid-operation:**
  - Stimulus: `rst` asserted between clock edges during HOLD.
  - Required: outputs go to 0 and `inst_addr`=0xBFC00000 immediately.
